// File: rtl/ws2812_bit_serializer_if.sv
// Pixel handshake between the WS2812 register block (master) and the
// bit serializer (slave). Pixel width follows WS2812_RGBW_EN:
// 24 bits GRB by default, 32 bits GRBW when the macro is defined.
interface ws2812_bit_serializer_if #(
`ifdef WS2812_RGBW_EN
    parameter int PW = 32
`else
    parameter int PW = 24
`endif
);
    logic [PW-1:0] pix_data;
    logic          pix_last;
    logic          pix_valid;
    logic          pix_ready;

    modport master (
        output pix_data,
        output pix_last,
        output pix_valid,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_last,
        input  pix_valid,
        output pix_ready
    );
endinterface

// File: rtl/ws2812_bit_serializer.sv
// WS2812 single-wire NRZ bit serializer.
// Takes pixel words over a valid/ready handshake, shifts them out MSB-first
// as TBIT-cycle bit periods (T1H or T0H high cycles), and after a pixel
// tagged last holds the line low for TRESET cycles before pulsing frame_done.
// Optional feature macro WS2812_RGBW_EN: 32-bit GRBW pixels instead of 24-bit GRB.
module ws2812_bit_serializer #(
    parameter int T0H    = 40,
    parameter int T1H    = 80,
    parameter int TBIT   = 125,
    parameter int TRESET = 5000
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    ws2812_bit_serializer_if.slave  pix,
    output logic                    dout,
    output logic                    busy,
    output logic                    frame_done
);

`ifdef WS2812_RGBW_EN
    localparam int PW = 32;
`else
    localparam int PW = 24;
`endif
    // cnt spans both bit timing and the latch period; TRESET-1 is the largest value
    localparam int CW = $clog2(TRESET);
    localparam int BW = $clog2(PW);

    localparam logic [CW-1:0] T0H_C     = CW'(T0H);
    localparam logic [CW-1:0] T1H_C     = CW'(T1H);
    localparam logic [CW-1:0] TBIT_M1   = CW'(TBIT - 1);
    localparam logic [CW-1:0] TRESET_M1 = CW'(TRESET - 1);
    localparam logic [BW-1:0] BIT_TOP   = BW'(PW - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    logic [1:0]    state, state_n;
    logic [PW-1:0] shreg, shreg_n;
    logic          last_q, last_n;
    logic [BW-1:0] bitidx, bitidx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          dout_n;

    logic [CW-1:0] thigh;
    logic          bit_end;
    logic          pix_end;
    logic          accept;

    assign thigh   = shreg[PW-1] ? T1H_C : T0H_C;
    assign bit_end = (state == S_SHIFT) && (cnt == TBIT_M1);
    assign pix_end = bit_end && (bitidx == '0);

    // Ready in IDLE, or on the final cycle of a non-last pixel so the next
    // pixel starts with no gap on the line.
    assign pix.pix_ready = (state == S_IDLE) || (pix_end && !last_q);
    assign accept        = pix.pix_valid && pix.pix_ready;

    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_LATCH) && (cnt == TRESET_M1);

    // Next-state, counter, shifter and line-level computation
    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        last_n   = last_q;
        bitidx_n = bitidx;
        cnt_n    = cnt;
        dout_n   = 1'b0;
        if (accept) begin
            // Every bit period opens with a high cycle, hence dout_n=1 on load
            state_n  = S_SHIFT;
            shreg_n  = pix.pix_data;
            last_n   = pix.pix_last;
            bitidx_n = BIT_TOP;
            cnt_n    = '0;
            dout_n   = 1'b1;
        end else begin
            case (state)
                S_SHIFT: begin
                    if (bit_end) begin
                        cnt_n = '0;
                        if (bitidx == '0) begin
                            // Pixel finished without a follow-up: latch or underrun
                            state_n = last_q ? S_LATCH : S_IDLE;
                        end else begin
                            shreg_n  = shreg << 1;
                            bitidx_n = bitidx - 1'b1;
                            dout_n   = 1'b1;
                        end
                    end else begin
                        cnt_n  = cnt + 1'b1;
                        dout_n = ((cnt + 1'b1) < thigh);
                    end
                end
                S_LATCH: begin
                    if (cnt == TRESET_M1) begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously at any point
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state  <= S_IDLE;
            shreg  <= '0;
            last_q <= 1'b0;
            bitidx <= '0;
            cnt    <= '0;
            dout   <= 1'b0;
        end else begin
            state  <= state_n;
            shreg  <= shreg_n;
            last_q <= last_n;
            bitidx <= bitidx_n;
            cnt    <= cnt_n;
            dout   <= dout_n;
        end
    end

endmodule
